sig_arbiter: RTL and testbench
==============================

SIG_ARBITER -- requirements
Module: sig_arbiter

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- width, 16, fixed-point word width
- int_bits, 3, integer bits of z
- frac_bits, 12, fractional bits of z
- NREQ, 4, number of requesters
- LUT_LAT, 1, clock cycles from table input z to table output
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, sole clock, rising edge
- reset_n, in, 1, asynchronous active-low reset
- en, in, 1, grant enable; when low, no new grants
- req_valid, in, NREQ, per-requester request valid
- req_ready, out, NREQ, per-requester grant (one-hot or zero)
- req_z, in, NREQ*width, packed z operands; requester i at [i*width +: width]
- req_prime, in, NREQ, 0 = sigmoid, 1 = sigmoid derivative
- tbl_z, out, width, z to the shared sigmoid/sig_prime table pair
- tbl_s, in, width, sigmoid table output
- tbl_sp, in, width, derivative table output
- rsp_valid, out, NREQ, one-hot result strobe to the owning requester
- rsp_data, out, width, result word

Function
REQ-003 The block SHALL grant at most one requester per cycle; req_ready[i] SHALL be high only when en=1 and req_valid[i]=1.
REQ-004 req_ready SHALL be combinational from req_valid, en and the priority pointer; a transfer occurs on a cycle where req_valid[i] and req_ready[i] are both 1.
REQ-005 On a transfer from requester i at edge t, the block SHALL register tbl_z = req_z[i] at edge t.
REQ-006 The block SHALL carry a tag {valid, id, prime} through a LUT_LAT-stage shift register aligned with the table latency.
REQ-007 At edge t+1+LUT_LAT, the block SHALL register rsp_data = tbl_sp if prime=1, else tbl_s, and pulse rsp_valid[id] for exactly one cycle.
REQ-008 The total request-to-response latency SHALL be exactly LUT_LAT+1 cycles after the transfer edge, at one accepted request per cycle sustained throughput.
REQ-009 Responses SHALL NOT be back-pressured; requesters SHALL accept rsp_valid in the cycle it is asserted.
REQ-010 On a cycle with no transfer, tbl_z SHALL hold its value, and a tag with valid=0 SHALL enter the pipeline.
REQ-011 On a cycle with no response, rsp_valid SHALL be 0 and rsp_data SHALL hold its last value.
REQ-012 The priority pointer ptr (log2 NREQ bits) SHALL update on a transfer from requester i to (i+1) mod NREQ, wrapping NREQ-1 -> 0, and SHALL hold otherwise.
REQ-013 Deasserting en SHALL NOT drop in-flight tags; they complete normally.
REQ-014 Requests from different requesters SHALL return in grant order; no reordering is permitted.

Reset
REQ-015 reset_n low SHALL asynchronously clear tbl_z, rsp_data, rsp_valid, all tag valid bits and ptr to 0.
REQ-016 Requests in flight when reset asserts SHALL be discarded with no rsp_valid produced; the first grant after reset release SHALL follow the ptr=0 rule.

Configuration
REQ-017 With SIG_ARB_RR_EN defined, grant selection SHALL be round-robin: the lowest i such that (ptr+k) mod NREQ = i for the smallest k with req_valid[i]=1.
REQ-018 Without SIG_ARB_RR_EN, grant selection SHALL be fixed priority (lowest index wins); ptr SHALL be omitted.

Verification
REQ-019 The bench SHALL cover the following scenarios (with LUT_LAT=1, unless noted):
- Single request: requester 0, z=16'h1000 (1.0), prime=0, transfer at edge 1 -> rsp_valid=4'b0001 at edge 3, rsp_data equal to the sigmoid_t output for z=16'h1000.
- Derivative request: requester 2, z=16'hE000 (-2.0), prime=1 -> rsp_valid=4'b0100, two cycles after the transfer, rsp_data equal to the sig_prime output for z=16'hE000.
- All four requesters valid continuously with RR enabled -> grants 0,1,2,3,0 on consecutive cycles, and responses in the same order one per cycle. With RR disabled -> requester 0 is granted every cycle.
- Reset mid-flight: reset_n driven low one cycle after a transfer -> no rsp_valid is produced, and all outputs read 0.
- en=0 while req_valid=4'b1111 -> req_ready=0 for the whole interval; a request accepted before en fell still returns its response.
- LUT_LAT=3 build, z=16'h7C00 (7.75) -> the response arrives exactly 4 cycles after the transfer.

Source files
------------

// File: rtl/sig_arbiter.sv
// sig_arbiter: shares one sigmoid / sigmoid-derivative table pair among NREQ requesters.
// Define SIG_ARB_RR_EN for round-robin grants; the default build uses fixed priority (lowest index wins).
module sig_arbiter #(
    parameter int width     = 16,
    parameter int int_bits  = 3,
    parameter int frac_bits = 12,
    parameter int NREQ      = 4,
    parameter int LUT_LAT   = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  en,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*width-1:0] req_z,
    input  logic [NREQ-1:0]       req_prime,
    output logic [width-1:0]      tbl_z,
    input  logic [width-1:0]      tbl_s,
    input  logic [width-1:0]      tbl_sp,
    output logic [NREQ-1:0]       rsp_valid,
    output logic [width-1:0]      rsp_data
);
    localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    if (int_bits + frac_bits + 1 != width) begin : g_fmt_check
        $error("sig_arbiter: width must equal 1 + int_bits + frac_bits");
    end

    logic [NREQ-1:0] gnt;
    logic [ID_W-1:0] gnt_id;
    logic            xfer;

`ifdef SIG_ARB_RR_EN
    logic [ID_W-1:0] ptr;

    // Search starts at ptr and walks upward with wrap; first valid requester wins.
    always_comb begin
        logic            found;
        logic [ID_W-1:0] idx;
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        idx    = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = ID_W'((32'(ptr) + k) % NREQ);
            if (en && !found && req_valid[idx]) begin
                gnt[idx] = 1'b1;
                gnt_id   = idx;
                found    = 1'b1;
            end
        end
    end
`else
    always_comb begin
        logic found;
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (en && !found && req_valid[i]) begin
                gnt[i] = 1'b1;
                gnt_id = ID_W'(i);
                found  = 1'b1;
            end
        end
    end
`endif

    assign req_ready = gnt;
    assign xfer      = |gnt;

    // Stage 0 is loaded together with tbl_z; stages 1..LUT_LAT track the table's own latency.
    logic [LUT_LAT:0] tag_valid;
    logic [LUT_LAT:0] tag_prime;
    logic [ID_W-1:0]  tag_id [LUT_LAT+1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tbl_z     <= '0;
            tag_valid <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
`ifdef SIG_ARB_RR_EN
            ptr       <= '0;
`endif
        end else begin
            if (xfer) begin
                tbl_z <= req_z[32'(gnt_id) * width +: width];
            end
            tag_valid[0] <= xfer;
            for (int unsigned s = 1; s <= LUT_LAT; s++) begin
                tag_valid[s] <= tag_valid[s-1];
            end
            if (tag_valid[LUT_LAT]) begin
                rsp_valid <= NREQ'(1) << tag_id[LUT_LAT];
                rsp_data  <= tag_prime[LUT_LAT] ? tbl_sp : tbl_s;
            end else begin
                rsp_valid <= '0;
            end
`ifdef SIG_ARB_RR_EN
            if (xfer) begin
                ptr <= (gnt_id == ID_W'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
            end
`endif
        end
    end

    // Tag payload only matters while its valid bit is set, so it needs no reset.
    always_ff @(posedge clk) begin
        tag_id[0]    <= gnt_id;
        tag_prime[0] <= req_prime[gnt_id];
        for (int unsigned s = 1; s <= LUT_LAT; s++) begin
            tag_id[s]    <= tag_id[s-1];
            tag_prime[s] <= tag_prime[s-1];
        end
    end

endmodule

// File: tb/tb_sig_arbiter.sv
// Directed bench for sig_arbiter: two instances (LUT_LAT=1 and LUT_LAT=3) fed from bench-side table models.
// Grant-order expectations follow SIG_ARB_RR_EN when it is defined for the build.
module tb_sig_arbiter;
    localparam int W = 16;
    localparam int N = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           reset_n;
    logic           en;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_prime;
    logic [N*W-1:0] req_z;

    logic [N-1:0]   a_ready, b_ready;
    logic [W-1:0]   a_tbl_z, b_tbl_z;
    logic [W-1:0]   a_tbl_s, a_tbl_sp, b_tbl_s, b_tbl_sp;
    logic [N-1:0]   a_rsp_valid, b_rsp_valid;
    logic [W-1:0]   a_rsp_data, b_rsp_data;

    sig_arbiter #(.width(W), .int_bits(3), .frac_bits(12), .NREQ(N), .LUT_LAT(1)) u_dut_a (
        .clk(clk), .reset_n(reset_n), .en(en),
        .req_valid(req_valid), .req_ready(a_ready), .req_z(req_z), .req_prime(req_prime),
        .tbl_z(a_tbl_z), .tbl_s(a_tbl_s), .tbl_sp(a_tbl_sp),
        .rsp_valid(a_rsp_valid), .rsp_data(a_rsp_data)
    );

    sig_arbiter #(.width(W), .int_bits(3), .frac_bits(12), .NREQ(N), .LUT_LAT(3)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .en(en),
        .req_valid(req_valid), .req_ready(b_ready), .req_z(req_z), .req_prime(req_prime),
        .tbl_z(b_tbl_z), .tbl_s(b_tbl_s), .tbl_sp(b_tbl_sp),
        .rsp_valid(b_rsp_valid), .rsp_data(b_rsp_data)
    );

    // Stand-in table contents: arbitrary but distinct per z and per function.
    function automatic logic [15:0] tbl_sig(input logic [15:0] z);
        return {z[7:0], z[15:8]} ^ 16'h0F0F;
    endfunction

    function automatic logic [15:0] tbl_der(input logic [15:0] z);
        return ~z + 16'd3;
    endfunction

    logic [W-1:0] b_s_pipe  [3];
    logic [W-1:0] b_sp_pipe [3];

    always_ff @(posedge clk) begin
        a_tbl_s      <= tbl_sig(a_tbl_z);
        a_tbl_sp     <= tbl_der(a_tbl_z);
        b_s_pipe[0]  <= tbl_sig(b_tbl_z);
        b_sp_pipe[0] <= tbl_der(b_tbl_z);
        b_s_pipe[1]  <= b_s_pipe[0];
        b_sp_pipe[1] <= b_sp_pipe[0];
        b_s_pipe[2]  <= b_s_pipe[1];
        b_sp_pipe[2] <= b_sp_pipe[1];
    end
    assign b_tbl_s  = b_s_pipe[2];
    assign b_tbl_sp = b_sp_pipe[2];

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    logic [N-1:0] exp_gnt [5];
    logic [W-1:0] exp_dat [5];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
`ifdef SIG_ARB_RR_EN
        exp_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_dat = '{16'h0F1F, 16'h0F2F, 16'h0F3F, 16'h0F4F, 16'h0F1F};
`else
        exp_gnt = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
        exp_dat = '{16'h0F1F, 16'h0F1F, 16'h0F1F, 16'h0F1F, 16'h0F1F};
`endif
        reset_n   = 1'b0;
        en        = 1'b0;
        req_valid = '0;
        req_prime = '0;
        req_z     = '0;
        repeat (2) @(negedge clk);
        check("rst_tbl_z", 32'(a_tbl_z), 0);
        check("rst_rsp_valid", 32'(a_rsp_valid), 0);
        check("rst_rsp_data", 32'(a_rsp_data), 0);
        reset_n = 1'b1;
        @(negedge clk);

        // single sigmoid request from requester 0
        en        = 1'b1;
        req_z     = {48'h0, 16'h1000};
        req_valid = 4'b0001;
        #1 check("single_ready", 32'(a_ready), 'h1);
        @(negedge clk);
        check("single_tbl_z", 32'(a_tbl_z), 'h1000);
        check("single_early0", 32'(a_rsp_valid), 0);
        req_valid = '0;
        @(negedge clk);
        check("single_early1", 32'(a_rsp_valid), 0);
        @(negedge clk);
        check("single_rsp_valid", 32'(a_rsp_valid), 'h1);
        check("single_rsp_data", 32'(a_rsp_data), 'h0F1F);
        @(negedge clk);
        check("single_pulse_end", 32'(a_rsp_valid), 0);
        check("single_data_hold", 32'(a_rsp_data), 'h0F1F);

        // derivative request from requester 2
        req_z     = {16'h0, 16'hE000, 32'h0};
        req_prime = 4'b0100;
        req_valid = 4'b0100;
        #1 check("deriv_ready", 32'(a_ready), 'h4);
        @(negedge clk);
        check("deriv_tbl_z", 32'(a_tbl_z), 'hE000);
        req_valid = '0;
        req_prime = '0;
        @(negedge clk);
        check("deriv_early", 32'(a_rsp_valid), 0);
        @(negedge clk);
        check("deriv_rsp_valid", 32'(a_rsp_valid), 'h4);
        check("deriv_rsp_data", 32'(a_rsp_data), 'h2002);
        @(negedge clk);
        check("deriv_pulse_end", 32'(a_rsp_valid), 0);

        // reset while a request is in flight
        req_z     = {48'h0, 16'h1000};
        req_valid = 4'b0001;
        @(negedge clk);
        check("midrst_tbl_z", 32'(a_tbl_z), 'h1000);
        req_valid = '0;
        reset_n   = 1'b0;
        #1;
        check("midrst_tbl_z0", 32'(a_tbl_z), 0);
        check("midrst_rsp_valid0", 32'(a_rsp_valid), 0);
        check("midrst_rsp_data0", 32'(a_rsp_data), 0);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check($sformatf("midrst_hold%0d", c), 32'(a_rsp_valid), 0);
        end
        reset_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("midrst_after%0d", c), 32'(a_rsp_valid), 0);
            check($sformatf("midrst_data%0d", c), 32'(a_rsp_data), 0);
        end

        // all four requesters valid for five consecutive grants
        req_z     = {16'h4000, 16'h3000, 16'h2000, 16'h1000};
        req_valid = 4'b1111;
        for (int c = 0; c <= 8; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 5) req_valid = '0;
            #1;
            if (c <= 4) check($sformatf("burst_ready%0d", c), 32'(a_ready), 32'(exp_gnt[c]));
            if (c >= 3 && c <= 7) begin
                check($sformatf("burst_rsp_valid%0d", c), 32'(a_rsp_valid), 32'(exp_gnt[c-3]));
                check($sformatf("burst_rsp_data%0d", c), 32'(a_rsp_data), 32'(exp_dat[c-3]));
            end else begin
                check($sformatf("burst_idle%0d", c), 32'(a_rsp_valid), 0);
            end
        end

        // en drops right after a transfer; the in-flight request still completes
        req_valid = 4'b0010;
        #1 check("en_pre_ready", 32'(a_ready), 'h2);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 1) begin
                en        = 1'b0;
                req_valid = 4'b1111;
            end
            #1;
            check($sformatf("en0_ready%0d", c), 32'(a_ready), 0);
            check($sformatf("en0_rsp_valid%0d", c), 32'(a_rsp_valid), (c == 3) ? 'h2 : 0);
            if (c == 3) check("en0_rsp_data", 32'(a_rsp_data), 'h0F2F);
        end
        req_valid = '0;
        en        = 1'b1;

        // LUT_LAT=3 instance: response four cycles after the transfer
        @(negedge clk);
        req_z     = {16'h7C00, 48'h0};
        req_valid = 4'b1000;
        #1 check("lat3_ready", 32'(b_ready), 'h8);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 1) req_valid = '0;
            #1;
            check($sformatf("lat3_rsp_valid%0d", c), 32'(b_rsp_valid), (c == 5) ? 'h8 : 0);
            if (c == 5) check("lat3_rsp_data", 32'(b_rsp_data), 'h0F73);
            if (c == 3) check("lat1_rsp_valid", 32'(a_rsp_valid), 'h8);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
